// File: rtl/i2s_pkg.sv
// Shared constants, FSM state type and width helper for the I2S transmitter.
package i2s_pkg;

    localparam int unsigned MODE_I2S = 0;
    localparam int unsigned MODE_LJ  = 1;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } tx_state_e;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous stereo-frame FIFO. A full FIFO rejects pushes even when popped in the same
// cycle; a pop on an empty FIFO is ignored even if a push lands in the same cycle.
module i2s_frame_fifo
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic [clog2(DEPTH):0]   count,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned PtrW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == (PtrW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// Stereo I2S / left-justified transmitter with internal bit clock, word select and a
// frame FIFO between the sample source and the serialiser.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned SLOT_W     = 32,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MODE       = 0
) (
    input  logic                        MasterCLK,
    input  logic                        Reset,
    input  logic                        Enable,
    input  logic [DATA_W-1:0]           InLeft,
    input  logic [DATA_W-1:0]           InRight,
    input  logic                        InValid,
    output logic                        InReady,
    output logic [clog2(FIFO_DEPTH):0]  Level,
    input  logic                        UnderrunClear,
    output logic                        Underrun,
    output logic                        SyncCLK,
    output logic                        I2S_CLK,
    output logic                        I2S_WS,
    output logic                        I2S_DATA
);

    localparam int unsigned BitW = clog2(2 * SLOT_W);
    localparam int unsigned DivW = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;
    localparam logic [BitW-1:0] BitMax = BitW'(2 * SLOT_W - 1);
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

    tx_state_e           state_q, state_d;
    logic [DivW-1:0]     div_q, div_d;
    logic                bclk_q, bclk_d;
    logic [BitW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0]   left_q, left_d;
    logic [DATA_W-1:0]   right_q, right_d;
    logic                data_q, data_d;
    logic                ws_q, ws_d;
    logic                sync_q, sync_d;
    logic                underrun_q, underrun_d;

    logic                  load;
    logic                  underrun_set;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [2*DATA_W-1:0]   fifo_rdata;
    logic [clog2(FIFO_DEPTH):0] fifo_count;

    i2s_frame_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (MasterCLK),
        .rst   (Reset),
        .push  (InValid),
        .pop   (fifo_pop),
        .wdata ({InLeft, InRight}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Serial bit driven during bit period b of the frame; slot padding is zero.
    function automatic logic serial_bit(input logic [DATA_W-1:0] l,
                                        input logic [DATA_W-1:0] r,
                                        input logic [BitW-1:0]   b);
        int unsigned       bi;
        int unsigned       p;
        logic [DATA_W-1:0] s;
        bi = 32'(b);
        if (bi >= SLOT_W) begin
            s = r;
            p = bi - SLOT_W;
        end else begin
            s = l;
            p = bi;
        end
        s = s << p;
        return (p < DATA_W) ? s[DATA_W-1] : 1'b0;
    endfunction

    // I2S mode switches WS one bit period ahead of the channel boundary.
    function automatic logic ws_for(input logic [BitW-1:0] b);
        int unsigned bi;
        bi = 32'(b);
        if (MODE == MODE_LJ) begin
            return bi >= SLOT_W;
        end
        if (b == BitMax) begin
            return 1'b0;
        end
        return (bi + 1) >= SLOT_W;
    endfunction

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        bclk_d       = bclk_q;
        bit_d        = bit_q;
        left_d       = left_q;
        right_d      = right_q;
        data_d       = data_q;
        ws_d         = ws_q;
        sync_d       = 1'b0;
        load         = 1'b0;
        fifo_pop     = 1'b0;
        underrun_set = 1'b0;

        unique case (state_q)
            StIdle: begin
                div_d  = '0;
                bclk_d = 1'b0;
                bit_d  = '0;
                data_d = 1'b0;
                ws_d   = 1'b0;
                if (Enable) begin
                    state_d = StRun;
                    load    = 1'b1;
                end
            end
            StRun: begin
                if (div_q == DivMax) begin
                    div_d  = '0;
                    bclk_d = ~bclk_q;
                    // Falling edge of the bit clock: advance to the next bit period.
                    if (bclk_q) begin
                        if (bit_q == BitMax) begin
                            bit_d = '0;
                            if (Enable) begin
                                load = 1'b1;
                            end else begin
                                state_d = StIdle;
                                data_d  = 1'b0;
                                ws_d    = 1'b0;
                            end
                        end else begin
                            bit_d  = bit_q + 1'b1;
                            data_d = serial_bit(left_q, right_q, bit_d);
                            ws_d   = ws_for(bit_d);
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Frame load: an empty FIFO still starts a frame, but of silence.
        if (load) begin
            fifo_pop     = 1'b1;
            underrun_set = fifo_empty;
            left_d       = fifo_empty ? '0 : fifo_rdata[2*DATA_W-1:DATA_W];
            right_d      = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
            div_d        = '0;
            bclk_d       = 1'b0;
            bit_d        = '0;
            data_d       = serial_bit(left_d, right_d, '0);
            ws_d         = ws_for('0);
            sync_d       = 1'b1;
        end

        underrun_d = underrun_set | (underrun_q & ~UnderrunClear);
    end

    always_ff @(posedge MasterCLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            div_q      <= '0;
            bclk_q     <= 1'b0;
            bit_q      <= '0;
            left_q     <= '0;
            right_q    <= '0;
            data_q     <= 1'b0;
            ws_q       <= 1'b0;
            sync_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            bit_q      <= bit_d;
            left_q     <= left_d;
            right_q    <= right_d;
            data_q     <= data_d;
            ws_q       <= ws_d;
            sync_q     <= sync_d;
            underrun_q <= underrun_d;
        end
    end

    assign InReady  = ~fifo_full;
    assign Level    = fifo_count;
    assign Underrun = underrun_q;
    assign SyncCLK  = sync_q;
    assign I2S_CLK  = bclk_q;
    assign I2S_WS   = ws_q;
    assign I2S_DATA = data_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench: a frame-level model queues expected bits per load; a monitor pops them on
// each observed bit-clock rise and also checks handshake, level, sync and underrun each cycle.
module tb_i2s_transmitter;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned SLOT_W     = 32;
    localparam int unsigned CLK_DIV    = 2;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FRAME_CYC  = 2 * SLOT_W * 2 * CLK_DIV;
    localparam int unsigned LVL_W      = 3;

    logic              MasterCLK, Reset, Enable, InValid, UnderrunClear;
    logic [DATA_W-1:0] InLeft, InRight;
    logic              rdy0, rdy1, ur0, ur1, sync0, sync1, clk0, clk1, ws0, ws1, dat0, dat1;
    logic [LVL_W-1:0]  lvl0, lvl1;

    typedef struct packed {
        logic data;
        logic ws_i2s;
        logic ws_lj;
    } bit_exp_t;

    bit_exp_t            bit_q[$];
    logic [2*DATA_W-1:0] frame_q[$];
    bit                  m_run, m_under, m_sync;
    int unsigned         m_cyc, m_loads;
    int                  errors, checks;

    i2s_transmitter #(
        .DATA_W(DATA_W), .SLOT_W(SLOT_W), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .MODE(0)
    ) u_dut_i2s (
        .MasterCLK(MasterCLK), .Reset(Reset), .Enable(Enable), .InLeft(InLeft),
        .InRight(InRight), .InValid(InValid), .InReady(rdy0), .Level(lvl0),
        .UnderrunClear(UnderrunClear), .Underrun(ur0), .SyncCLK(sync0), .I2S_CLK(clk0),
        .I2S_WS(ws0), .I2S_DATA(dat0)
    );

    i2s_transmitter #(
        .DATA_W(DATA_W), .SLOT_W(SLOT_W), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .MODE(1)
    ) u_dut_lj (
        .MasterCLK(MasterCLK), .Reset(Reset), .Enable(Enable), .InLeft(InLeft),
        .InRight(InRight), .InValid(InValid), .InReady(rdy1), .Level(lvl1),
        .UnderrunClear(UnderrunClear), .Underrun(ur1), .SyncCLK(sync1), .I2S_CLK(clk1),
        .I2S_WS(ws1), .I2S_DATA(dat1)
    );

    initial begin
        MasterCLK = 1'b0;
        forever #5 MasterCLK = ~MasterCLK;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40) begin
                $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
            end
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Frame-level reference: load times, FIFO contents, underrun flag, expected bit stream.
    task automatic model_step();
        logic [2*DATA_W-1:0] f;
        logic [DATA_W-1:0]   s;
        logic [DATA_W-1:0]   sh;
        int unsigned         pre, p;
        bit                  load;
        bit_exp_t            e;
        if (Reset) begin
            frame_q.delete();
            bit_q.delete();
            m_run = 0; m_cyc = 0; m_under = 0; m_sync = 0;
            return;
        end
        pre  = $unsigned(frame_q.size());
        load = 0;
        if (!m_run) begin
            load = Enable;
        end else if (m_cyc == FRAME_CYC - 1) begin
            if (Enable) load = 1;
            else begin m_run = 0; m_cyc = 0; end
        end else begin
            m_cyc++;
        end
        m_sync = load;
        if (UnderrunClear) m_under = 0;
        if (load) begin
            m_run = 1; m_cyc = 0; m_loads++;
            if (pre == 0) begin f = '0; m_under = 1; end
            else f = frame_q.pop_front();
            for (int unsigned b = 0; b < 2 * SLOT_W; b++) begin
                s  = (b < SLOT_W) ? f[2*DATA_W-1:DATA_W] : f[DATA_W-1:0];
                p  = b % SLOT_W;
                sh = (p < DATA_W) ? (s >> (DATA_W - 1 - p)) : '0;
                e.data   = sh[0];
                e.ws_lj  = (b >= SLOT_W);
                e.ws_i2s = (((b + 1) % (2 * SLOT_W)) >= SLOT_W);
                bit_q.push_back(e);
            end
        end
        if (InValid && pre != FIFO_DEPTH) frame_q.push_back({InLeft, InRight});
    endtask

    initial begin
        forever begin
            @(posedge MasterCLK or posedge Reset);
            model_step();
        end
    end

    // Monitor: cycle checks plus scoreboard pops on each bit-clock rise.
    initial begin
        logic        prev;
        logic        exp_clk;
        logic [2:0]  exp_lvl;
        bit_exp_t    e;
        prev = 1'b0;
        forever begin
            @(negedge MasterCLK);
            exp_clk = m_run ? (((m_cyc / CLK_DIV) % 2) == 1) : 1'b0;
            exp_lvl = 3'(frame_q.size());
            check("bclk_i2s", 32'(clk0), 32'(exp_clk));
            check("bclk_lj", 32'(clk1), 32'(exp_clk));
            check("sync", {sync0, sync1}, {m_sync, m_sync});
            check("level", {lvl0, lvl1}, {exp_lvl, exp_lvl});
            check("in_ready", {rdy0, rdy1}, {2{exp_lvl != 3'(FIFO_DEPTH)}});
            check("underrun", {ur0, ur1}, {m_under, m_under});
            if (!m_run) check("idle_out", {ws0, dat0, ws1, dat1}, 0);
            if (clk0 && !prev) begin
                if (bit_q.size() == 0) begin
                    timeout("bit_queue_empty");
                end else begin
                    e = bit_q.pop_front();
                    check("data_i2s", 32'(dat0), 32'(e.data));
                    check("data_lj", 32'(dat1), 32'(e.data));
                    check("ws_i2s", 32'(ws0), 32'(e.ws_i2s));
                    check("ws_lj", 32'(ws1), 32'(e.ws_lj));
                end
            end
            prev = clk0;
        end
    end

    task automatic step();
        @(negedge MasterCLK);
        #1;
    endtask

    task automatic push_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        InValid = 1'b1; InLeft = l; InRight = r;
        step();
        InValid = 1'b0;
    endtask

    task automatic wait_loads(input int unsigned n);
        int unsigned target;
        int unsigned budget;
        target = m_loads + n;
        budget = n * FRAME_CYC + 50;
        while (m_loads < target && budget > 0) begin
            step();
            budget--;
        end
        if (m_loads < target) timeout("wait_loads");
    endtask

    task automatic wait_idle();
        int unsigned budget;
        budget = 3 * FRAME_CYC;
        while (m_run && budget > 0) begin
            step();
            budget--;
        end
        if (m_run) timeout("wait_idle");
    endtask

    initial begin
        int unsigned budget;
        errors = 0; checks = 0; m_loads = 0;
        m_run = 0; m_cyc = 0; m_under = 0; m_sync = 0;
        Reset = 1'b1; Enable = 1'b0; InValid = 1'b0; UnderrunClear = 1'b0;
        InLeft = '0; InRight = '0;

        // Inputs toggling under reset must not disturb anything.
        repeat (6) begin
            step();
            Enable = 1'($urandom); InValid = 1'($urandom); UnderrunClear = 1'($urandom);
            InLeft = DATA_W'($urandom); InRight = DATA_W'($urandom);
        end
        step();
        Enable = 1'b0; InValid = 1'b0; UnderrunClear = 1'b0;
        Reset = 1'b0;
        repeat (12) step();

        // Known pattern, single frame.
        push_frame(16'hA5A5, 16'h5A5A);
        Enable = 1'b1;
        wait_loads(1);
        Enable = 1'b0;
        wait_idle();

        // Underrun frame, then clear it while pushing data for the next frame.
        Enable = 1'b1;
        wait_loads(1);
        repeat (40) step();
        UnderrunClear = 1'b1;
        push_frame(DATA_W'($urandom), DATA_W'($urandom));
        UnderrunClear = 1'b0;
        wait_loads(1);
        Enable = 1'b0;
        wait_idle();

        // Overflow: five back-to-back pushes into an idle FIFO, then drain four frames.
        repeat (5) push_frame(DATA_W'($urandom), DATA_W'($urandom));
        repeat (4) step();
        Enable = 1'b1;
        wait_loads(4);
        Enable = 1'b0;
        wait_idle();

        // Randomised traffic while running.
        Enable = 1'b1;
        for (int unsigned i = 0; i < 6 * FRAME_CYC; i++) begin
            InValid       = ($urandom_range(0, 7) == 0);
            InLeft        = DATA_W'($urandom);
            InRight       = DATA_W'($urandom);
            UnderrunClear = ($urandom_range(0, 63) == 0);
            step();
        end
        InValid = 1'b0; UnderrunClear = 1'b0; Enable = 1'b0;
        wait_idle();

        // Reset in the middle of bit period 20, then restart cleanly.
        push_frame(DATA_W'($urandom), DATA_W'($urandom));
        push_frame(DATA_W'($urandom), DATA_W'($urandom));
        Enable = 1'b1;
        budget = 2 * FRAME_CYC;
        while (!(m_run && m_cyc == 20 * 2 * CLK_DIV + 1) && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) timeout("wait_bit20");
        Reset = 1'b1; Enable = 1'b0;
        step();
        Reset = 1'b0;
        repeat (5) step();
        push_frame(DATA_W'($urandom), DATA_W'($urandom));
        Enable = 1'b1;
        wait_loads(1);
        Enable = 1'b0;
        wait_idle();
        repeat (4) step();

        check("bits_left", $unsigned(bit_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
